// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and fills the IF/ID pipeline register.
// A branch redirect flushes IF/ID. A hazard stall holds the PC and IF/ID.
module fetch_unit #(
  parameter int unsigned         PC_W     = 9,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter logic [31:0]         NOP      = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            pc_sel_i,
  input  logic [31:0]     br_pc_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_rvalid_i,
  output logic [PC_W-1:0] ifid_pc_o,
  output logic [31:0]     ifid_instr_o,
  output logic            ifid_valid_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            kill;
  logic [31:0]     hold_word;

  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] pc_next_seq;
  logic            load_en;
  logic [31:0]     load_word;
  logic            unused_br_bits;

  // Redirect target is forced word aligned; sequential PC wraps at 2^PC_W.
  assign redirect_pc    = {br_pc_i[PC_W-1:2], 2'b00};
  assign pc_next_seq    = pc + PC_W'(4);
  assign unused_br_bits = ^{br_pc_i[31:PC_W], br_pc_i[1:0]};

  // Request strobe is driven straight from the state; held low during reset.
  assign imem_req_o  = (state == S_FETCH) && !reset;
  assign imem_addr_o = pc;

  // Decide whether a real instruction enters IF/ID this cycle, and which word.
  always_comb begin
    load_en   = 1'b0;
    load_word = hold_word;
    case (state)
      S_WAIT: begin
        if (imem_rvalid_i && !kill && !pc_sel_i && !stall_i) begin
          load_en   = 1'b1;
          load_word = imem_rdata_i;
        end
      end
      S_HOLD: begin
        if (!pc_sel_i && !stall_i) begin
          load_en = 1'b1;
        end
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // Fetch FSM, PC, kill flag and stall buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      hold_word <= NOP;
    end else begin
      case (state)
        S_FETCH: begin
          state <= S_WAIT;
          if (pc_sel_i) begin
            pc   <= redirect_pc;
            kill <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (kill || pc_sel_i) begin
              kill  <= 1'b0;
              state <= S_FETCH;
              if (pc_sel_i) begin
                pc <= redirect_pc;
              end
            end else if (stall_i) begin
              hold_word <= imem_rdata_i;
              state     <= S_HOLD;
            end else begin
              pc    <= pc_next_seq;
              state <= S_FETCH;
            end
          end else if (pc_sel_i) begin
            pc   <= redirect_pc;
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (pc_sel_i) begin
            pc    <= redirect_pc;
            state <= S_FETCH;
          end else if (!stall_i) begin
            pc    <= pc_next_seq;
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall beats load beats bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_pc_o    <= '0;
      ifid_instr_o <= NOP;
      ifid_valid_o <= 1'b0;
    end else if (pc_sel_i) begin
      ifid_instr_o <= NOP;
      ifid_valid_o <= 1'b0;
    end else if (stall_i) begin
      ifid_valid_o <= ifid_valid_o;
    end else if (load_en) begin
      ifid_pc_o    <= pc;
      ifid_instr_o <= load_word;
      ifid_valid_o <= 1'b1;
    end else begin
      ifid_instr_o <= NOP;
      ifid_valid_o <= 1'b0;
    end
  end

endmodule
